sensor_hit_detector: RTL and testbench

- Parametrised front end for the box sensors: synchronises N_CH raw GPIO sensor lines and debounces each one.
- Turns each rising edge into a queued hit event, presented as a box address on a valid/ready handshake to the game FSM.
- Drives the LED mirror of the debounced levels and a HEX digit showing the last accepted box address.
- Sits between the GPIO header and the game controller.

---
 rtl/sensor_pkg.sv | 11 +
 rtl/hex_decoder.sv | 32 +++
 rtl/sensor_debounce.sv | 70 +++++++
 rtl/sensor_hit_detector.sv | 81 ++++++++
 tb/tb_sensor_hit_detector.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/sensor_pkg.sv
// Shared constants and types for the box-sensor front end.
package sensor_pkg;

  localparam int MAX_CH = 15;

  localparam logic [6:0] HEX_BLANK = 7'b1111111;
  localparam logic [6:0] HEX_ZERO  = 7'b1000000;

  typedef logic [3:0] box_addr_t;

endpackage

// File: rtl/hex_decoder.sv
// Active-low seven-segment decoder (segment order gfedcba) for one hex digit.
module hex_decoder
  import sensor_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  always_comb begin
    seg = HEX_BLANK;
    case (digit)
      4'h0: seg = HEX_ZERO;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110;
      4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110;
      4'hF: seg = 7'b0001110;
      default: seg = HEX_BLANK;
    endcase
  end

endmodule

// File: rtl/sensor_debounce.sv
// One sensor channel: 2-flop synchroniser, debounce counter and stable level with rise pulse.
// Counter is present only when SENSOR_DEBOUNCE_EN is defined; otherwise stable follows s2.
module sensor_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clock,
  input  logic resetn,
  input  logic raw,
  output logic level,
  output logic rise
);

  if (DEBOUNCE_CYCLES < 1) begin : g_bad_param
    $error("sensor_debounce: DEBOUNCE_CYCLES must be >= 1");
  end

  logic sync_p0;
  logic sync_p1;
  logic stable_p2;
  logic stable_p3;

  // Stage p0/p1: metastability synchroniser
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
    end else begin
      sync_p0 <= raw;
      sync_p1 <= sync_p0;
    end
  end

`ifdef SENSOR_DEBOUNCE_EN
  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0] cnt_p2;

  // Stage p2: accept a new level after DEBOUNCE_CYCLES consecutive differing samples
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      cnt_p2    <= '0;
      stable_p2 <= 1'b0;
    end else if (sync_p1 == stable_p2) begin
      cnt_p2 <= '0;
    end else if (cnt_p2 == CNT_LAST) begin
      cnt_p2    <= '0;
      stable_p2 <= sync_p1;
    end else begin
      cnt_p2 <= cnt_p2 + 1'b1;
    end
  end
`else
  // Stage p2: unfiltered level
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) stable_p2 <= 1'b0;
    else         stable_p2 <= sync_p1;
  end
`endif

  // Stage p3: previous level for edge detection
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) stable_p3 <= 1'b0;
    else         stable_p3 <= stable_p2;
  end

  assign level = stable_p2;
  assign rise  = stable_p2 & ~stable_p3;

endmodule

// File: rtl/sensor_hit_detector.sv
// Box-sensor front end: debounced channels, pending-hit queue with valid/ready, drop flag, HEX/LED.
// Optional macro SENSOR_DEBOUNCE_EN enables the per-channel debounce counters.
module sensor_hit_detector
  import sensor_pkg::*;
#(
  parameter  int N_CH            = 3,
  parameter  int DEBOUNCE_CYCLES = 500000,
  localparam int ADDR_W          = $clog2(N_CH + 1)
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic [N_CH-1:0]   sensor_in,
  output logic              hit_valid,
  output logic [ADDR_W-1:0] hit_addr,
  input  logic              hit_ready,
  input  logic              drop_clear,
  output logic              drop,
  output logic [N_CH-1:0]   sensor_level,
  output logic [6:0]        hex_display
);

  if (N_CH < 1 || N_CH > MAX_CH) begin : g_bad_param
    $error("sensor_hit_detector: N_CH must be in 1..15");
  end

  logic [N_CH-1:0]   rise;
  logic [N_CH-1:0]   pending;
  logic [N_CH-1:0]   sel;
  logic [N_CH-1:0]   clear_vec;
  logic [ADDR_W-1:0] addr_c;
  logic              xfer;
  logic              drop_hit;
  box_addr_t         last_addr;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    sensor_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clock  (clock),
      .resetn (resetn),
      .raw    (sensor_in[g]),
      .level  (sensor_level[g]),
      .rise   (rise[g])
    );
  end

  // Lowest pending index wins; address is index + 1 so 0 means "nothing".
  always_comb begin
    addr_c = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (pending[i]) addr_c = ADDR_W'(i + 1);
    end
  end

  assign sel       = pending & (~pending + N_CH'(1));
  assign hit_valid = |pending;
  assign hit_addr  = addr_c;
  assign xfer      = hit_valid & hit_ready;
  assign clear_vec = xfer ? sel : '0;
  // A rise re-arms a bit that is leaving this cycle; only a still-occupied bit loses the event.
  assign drop_hit  = |(rise & pending & ~clear_vec);

  // Queue, drop and display state
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      pending   <= '0;
      last_addr <= '0;
      drop      <= 1'b0;
    end else begin
      pending <= (pending & ~clear_vec) | rise;
      drop    <= drop_hit | (drop & ~drop_clear);
      if (xfer) last_addr <= box_addr_t'(hit_addr);
    end
  end

  hex_decoder u_hex (
    .digit (last_addr),
    .seg   (hex_display)
  );

endmodule

// File: tb/tb_sensor_hit_detector.sv
// Directed bench for sensor_hit_detector (N_CH=3, DEBOUNCE_CYCLES=4); latency follows SENSOR_DEBOUNCE_EN.
module tb_sensor_hit_detector;

`ifdef SENSOR_DEBOUNCE_EN
  localparam int DB = 4;
`else
  localparam int DB = 1;
`endif

  logic       clock = 1'b0;
  logic       resetn;
  logic [2:0] sensor_in;
  logic       hit_valid;
  logic [1:0] hit_addr;
  logic       hit_ready;
  logic       drop_clear;
  logic       drop;
  logic [2:0] sensor_level;
  logic [6:0] hex_display;

  int n_checks = 0;
  int n_fail   = 0;

  sensor_hit_detector #(
    .N_CH            (3),
    .DEBOUNCE_CYCLES (4)
  ) dut (
    .clock        (clock),
    .resetn       (resetn),
    .sensor_in    (sensor_in),
    .hit_valid    (hit_valid),
    .hit_addr     (hit_addr),
    .hit_ready    (hit_ready),
    .drop_clear   (drop_clear),
    .drop         (drop),
    .sensor_level (sensor_level),
    .hex_display  (hex_display)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [2:0] mask;
    int         n;
    int         a0;
    int         a1;
    int         a2;
    logic [6:0] hex;
  } vec_t;

  vec_t tbl [5];

  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_valid(output int k);
    bit found;
    found = 1'b0;
    k = -1;
    for (int i = 1; i <= DB + 13; i++) begin
      if (!found) begin
        step();
        if (hit_valid) begin
          found = 1'b1;
          k = i;
        end
      end
    end
  endtask

  task automatic settle();
    bit seen;
    seen = 1'b0;
    sensor_in = 3'b000;
    hit_ready = 1'b1;
    repeat (DB + 5) begin
      step();
      if (hit_valid) seen = 1'b1;
    end
    hit_ready = 1'b0;
    chk("fall_no_event", int'(seen), 0);
    chk("level_low", int'(sensor_level), 0);
  endtask

  initial begin
    int k;
    int n_obs;
    int first;
    int obs [4];
    bit seen_v;
    bit seen_l;

    tbl[0] = '{mask: 3'b100, n: 1, a0: 3, a1: 0, a2: 0, hex: 7'b0110000};
    tbl[1] = '{mask: 3'b010, n: 1, a0: 2, a1: 0, a2: 0, hex: 7'b0100100};
    tbl[2] = '{mask: 3'b101, n: 2, a0: 1, a1: 3, a2: 0, hex: 7'b0110000};
    tbl[3] = '{mask: 3'b001, n: 1, a0: 1, a1: 0, a2: 0, hex: 7'b1111001};
    tbl[4] = '{mask: 3'b111, n: 3, a0: 1, a1: 2, a2: 3, hex: 7'b0110000};

    // Reset with all sensors high
    resetn     = 1'b1;
    sensor_in  = 3'b111;
    hit_ready  = 1'b0;
    drop_clear = 1'b0;
    #1 resetn = 1'b0;
    repeat (3) step();
    chk("rst_hit_valid", int'(hit_valid), 0);
    chk("rst_hit_addr", int'(hit_addr), 0);
    chk("rst_drop", int'(drop), 0);
    chk("rst_level", int'(sensor_level), 0);
    chk("rst_hex", int'(hex_display), int'(7'b1000000));
    resetn = 1'b1;
    wait_valid(k);
    chk("rst_release_latency", k, 3 + DB);
    chk("rst_release_level", int'(sensor_level), 7);
    hit_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("rst_drain_valid", int'(hit_valid), 1);
      chk("rst_drain_addr", int'(hit_addr), i + 1);
      step();
    end
    chk("rst_drain_empty", int'(hit_valid), 0);
    chk("rst_drain_hex", int'(hex_display), int'(7'b0110000));
    settle();

`ifdef SENSOR_DEBOUNCE_EN
    // Glitch shorter than the debounce window
    seen_v = 1'b0;
    seen_l = 1'b0;
    sensor_in = 3'b010;
    repeat (3) begin
      step();
      if (hit_valid) seen_v = 1'b1;
      if (sensor_level != 3'b000) seen_l = 1'b1;
    end
    sensor_in = 3'b000;
    repeat (DB + 6) begin
      step();
      if (hit_valid) seen_v = 1'b1;
      if (sensor_level != 3'b000) seen_l = 1'b1;
    end
    chk("glitch_no_valid", int'(seen_v), 0);
    chk("glitch_no_level", int'(seen_l), 0);
`endif

    // Single hit held by the consumer
    sensor_in = 3'b010;
    wait_valid(k);
    chk("single_latency", k, 3 + DB);
    chk("single_addr", int'(hit_addr), 2);
    repeat (3) step();
    chk("single_hold_valid", int'(hit_valid), 1);
    chk("single_hold_addr", int'(hit_addr), 2);
    hit_ready = 1'b1;
    step();
    hit_ready = 1'b0;
    chk("single_after_valid", int'(hit_valid), 0);
    chk("single_hex", int'(hex_display), int'(7'b0100100));
    settle();

    // Table: raise a mask with the consumer always ready
    for (int r = 0; r < 5; r++) begin
      sensor_in = tbl[r].mask;
      hit_ready = 1'b1;
      n_obs = 0;
      first = -1;
      for (int c = 1; c <= 3 + DB + 6; c++) begin
        step();
        if (hit_valid) begin
          if (first < 0) first = c;
          if (n_obs < 4) obs[n_obs] = int'(hit_addr);
          n_obs++;
        end
      end
      chk("tbl_latency", first, 3 + DB);
      chk("tbl_count", n_obs, tbl[r].n);
      if (n_obs >= 1) chk("tbl_addr0", obs[0], tbl[r].a0);
      if (n_obs >= 2) chk("tbl_addr1", obs[1], tbl[r].a1);
      if (n_obs >= 3) chk("tbl_addr2", obs[2], tbl[r].a2);
      chk("tbl_hex", int'(hex_display), int'(tbl[r].hex));
      chk("tbl_level", int'(sensor_level), int'(tbl[r].mask));
      settle();
    end

    // Drop: second rise on a channel whose event is still pending
    sensor_in = 3'b001;
    wait_valid(k);
    chk("drop_first_latency", k, 3 + DB);
    sensor_in = 3'b000;
    repeat (DB + 4) step();
    chk("drop_still_pending", int'(hit_valid), 1);
    chk("drop_level_fell", int'(sensor_level), 0);
    chk("drop_not_yet", int'(drop), 0);
    sensor_in = 3'b001;
    repeat (DB + 4) step();
    chk("drop_set", int'(drop), 1);
    chk("drop_valid", int'(hit_valid), 1);
    chk("drop_addr", int'(hit_addr), 1);
    hit_ready = 1'b1;
    step();
    hit_ready = 1'b0;
    chk("drop_one_event", int'(hit_valid), 0);
    chk("drop_sticky", int'(drop), 1);
    drop_clear = 1'b1;
    step();
    drop_clear = 1'b0;
    chk("drop_cleared", int'(drop), 0);
    settle();

    // Rise on a channel in the same cycle its event is accepted: requeued, no drop
    sensor_in = 3'b001;
    wait_valid(k);
    chk("coin_first_latency", k, 3 + DB);
    sensor_in = 3'b000;
    repeat (DB + 4) step();
    sensor_in = 3'b001;
    repeat (2 + DB) step();
    hit_ready = 1'b1;
    step();
    chk("coin_requeued", int'(hit_valid), 1);
    chk("coin_addr", int'(hit_addr), 1);
    chk("coin_no_drop", int'(drop), 0);
    step();
    chk("coin_drained", int'(hit_valid), 0);
    chk("coin_no_drop_end", int'(drop), 0);
    settle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
